// File: rtl/exp5_unidade_controle.sv
// rtl/exp5_unidade_controle.sv - Moore control unit for the memory-game datapath
// Walks the memory one address per move; ends in acertou, errou or timeout.
module exp5_unidade_controle #(
    parameter int TIMEOUT = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TEMPO_ULTIMO = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERROU   = 4'hE
    } estado_t;

    estado_t       estado;
    estado_t       proximo;
    logic [CW-1:0] cont_tempo;
    logic          fim_tempo;

    assign fim_tempo = (cont_tempo == TEMPO_ULTIMO);
    assign db_estado = estado;

    // A jogada in the same cycle as the timeout wins.
    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:     proximo = iniciar ? PREPARA : INICIAL;
            PREPARA:     proximo = ESPERA;
            ESPERA: begin
                if (jogada)         proximo = REGISTRA;
                else if (fim_tempo) proximo = FIM_TIMEOUT;
                else                proximo = ESPERA;
            end
            REGISTRA:    proximo = COMPARA;
            COMPARA: begin
                if (!igual)    proximo = FIM_ERROU;
                else if (fimC) proximo = FIM_ACERTOU;
                else           proximo = PROXIMO;
            end
            PROXIMO:     proximo = ESPERA;
            FIM_ACERTOU: proximo = iniciar ? PREPARA : FIM_ACERTOU;
            FIM_ERROU:   proximo = iniciar ? PREPARA : FIM_ERROU;
            FIM_TIMEOUT: proximo = iniciar ? PREPARA : FIM_TIMEOUT;
            default:     proximo = INICIAL;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= INICIAL;
            cont_tempo <= '0;
            zeraC      <= 1'b0;
            contaC     <= 1'b0;
            zeraR      <= 1'b0;
            registraR  <= 1'b0;
            pronto     <= 1'b0;
            acertou    <= 1'b0;
            errou      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            estado <= proximo;
            if (estado == ESPERA && !jogada && !fim_tempo)
                cont_tempo <= cont_tempo + 1'b1;
            else
                cont_tempo <= '0;
            zeraC     <= (proximo == PREPARA);
            zeraR     <= (proximo == PREPARA);
            contaC    <= (proximo == PROXIMO);
            registraR <= (proximo == REGISTRA);
            pronto    <= (proximo == FIM_ACERTOU) || (proximo == FIM_ERROU) || (proximo == FIM_TIMEOUT);
            acertou   <= (proximo == FIM_ACERTOU);
            errou     <= (proximo == FIM_ERROU) || (proximo == FIM_TIMEOUT);
            timeout   <= (proximo == FIM_TIMEOUT);
        end
    end
endmodule

// File: tb/tb_exp5_unidade_controle.sv
// tb/tb_exp5_unidade_controle.sv - self-checking bench for exp5_unidade_controle
// Rounds are described as move lists; outcome and pulse counts come from a move-level model.
module tb_exp5_unidade_controle;
    localparam int TMO = 8;

    logic       clock = 1'b0;
    logic       reset, iniciar, jogada, igual, fimC;
    logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int dly[16];
    bit ig[16];
    bit fc[16];
    int nmov;
    bit jog_s[512];
    bit ig_s[512];
    bit fc_s[512];

    exp5_unidade_controle #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC),
        .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
        .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    function automatic logic [11:0] snap();
        return {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_moves(input int n);
        nmov = n;
        for (int i = 0; i < 16; i++) begin
            dly[i] = int'($urandom_range(0, TMO - 1));
            ig[i]  = 1'b1;
            fc[i]  = (i == n - 1);
        end
    endtask

    // Cycle 0 is PREPARA; a move with delay d occupies d+1 ESPERA cycles, then REGISTRA, COMPARA, then PROXIMO or a final state.
    task automatic play_round(input string tag, input int noise);
        int e_reg, e_cnt, e_cyc, e_esp, outcome, p;
        int n_zc, n_zr, n_reg, n_cnt, n_esp, n_pr, bad, fin;
        logic [11:0] fin_snap, e_snap;
        e_reg = 0; e_cnt = 0; e_cyc = 1; e_esp = 0; outcome = 0; p = 1;
        for (int c = 0; c < 512; c++) begin
            jog_s[c] = (noise == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            ig_s[c]  = 1'($urandom_range(0, 1));
            fc_s[c]  = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < nmov && outcome == 0; i++) begin
            if (dly[i] >= TMO) begin
                for (int k = 0; k < TMO; k++) jog_s[p + k] = 1'b0;
                e_esp += TMO;
                e_cyc += TMO;
                outcome = 3;
            end else begin
                for (int k = 0; k < dly[i]; k++) jog_s[p + k] = 1'b0;
                jog_s[p + dly[i]] = 1'b1;
                for (int k = 0; k <= dly[i] + 3; k++) begin
                    ig_s[p + k] = ig[i];
                    fc_s[p + k] = fc[i];
                end
                e_esp += dly[i] + 1;
                e_reg++;
                e_cyc += dly[i] + 3;
                p += dly[i] + 3;
                if (!ig[i])     outcome = 2;
                else if (fc[i]) outcome = 1;
                else begin
                    e_cnt++;
                    e_cyc++;
                    p++;
                end
            end
        end
        e_snap = (outcome == 1) ? 12'h0CA : (outcome == 2) ? 12'h0AE : 12'h0BD;

        n_zc = 0; n_zr = 0; n_reg = 0; n_cnt = 0; n_esp = 0; n_pr = 0; bad = 0;
        fin = -1; fin_snap = '0;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        for (int c = 0; c <= e_cyc + 3; c++) begin
            jogada = jog_s[c];
            igual  = ig_s[c];
            fimC   = fc_s[c];
            n_zc  += int'(zeraC);
            n_zr  += int'(zeraR);
            n_reg += int'(registraR);
            n_cnt += int'(contaC);
            n_pr  += int'(pronto);
            if (db_estado == 4'h2) n_esp++;
            if ((zeraC != zeraR) || (int'(zeraC) + int'(contaC) + int'(registraR) > 1)) bad++;
            if (pronto && fin < 0) begin
                fin = c;
                fin_snap = snap();
            end
            step();
        end
        jogada = 1'b0;
        check($sformatf("%s/zeraC", tag), n_zc, 1);
        check($sformatf("%s/zeraR", tag), n_zr, 1);
        check($sformatf("%s/registraR", tag), n_reg, e_reg);
        check($sformatf("%s/contaC", tag), n_cnt, e_cnt);
        check($sformatf("%s/espera_cycles", tag), n_esp, e_esp);
        check($sformatf("%s/end_cycle", tag), fin, e_cyc);
        check($sformatf("%s/final_outputs", tag), fin_snap, e_snap);
        check($sformatf("%s/pronto_held", tag), n_pr, 4);
        check($sformatf("%s/strobe_overlap", tag), bad, 0);
    endtask

    initial begin
        int bad;
        reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fimC = 1'b0;
        step();
        check("reset_state", snap(), 12'h000);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (snap() != 12'h000) bad++;
            step();
        end
        check("idle_inicial", bad, 0);

        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        check("prepara", snap(), 12'hA01);
        step();
        check("espera_after_prepara", snap(), 12'h002);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_in_espera", snap(), 12'h000);

        set_moves(16);
        play_round("full16", 0);

        set_moves(16);
        ig[2] = 1'b0;
        play_round("wrong3rd", 0);

        set_moves(4);
        ig[3] = 1'b0;
        play_round("wrong_last", 0);

        set_moves(1);
        dly[0] = TMO;
        play_round("timeout", 0);

        set_moves(1);
        dly[0] = TMO - 1;
        play_round("jogada_at_limit", 0);

        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
        jogada = 1'b1; igual = 1'b1; fimC = 1'b0;
        step();
        jogada = 1'b0;
        step();
        step();
        check("in_proximo", snap(), 12'h406);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_in_proximo", snap(), 12'h000);
        step();
        check("inicial_after_reset", snap(), 12'h000);

        set_moves(1);
        dly[0] = 0;
        play_round("short_ok", 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_in_acertou", snap(), 12'h000);

        set_moves(2);
        ig[0] = 1'b0;
        play_round("errou_first", 0);
        set_moves(1);
        dly[0] = TMO + 2;
        play_round("restart_timeout", 0);

        set_moves(3);
        play_round("noise_outside_espera", 1);

        for (int r = 0; r < 25; r++) begin
            set_moves(int'($urandom_range(1, 16)));
            for (int i = 0; i < nmov; i++) begin
                if ($urandom_range(0, 9) == 0) dly[i] = TMO + int'($urandom_range(0, 2));
                if ($urandom_range(0, 9) == 0) ig[i] = 1'b0;
            end
            play_round($sformatf("rand%0d", r), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/exp5_unidade_controle.md
# exp5_unidade_controle

Moore control unit sequencing the memory-game datapath: address counter, "chaves" register, and chaves-vs-memory comparator. After `iniciar`, it walks the memory one address per player move and ends the round in one of three outcomes: all moves correct, a wrong move, or no move within a timeout. It drives the datapath's zero, count and register strobes, exposes the result flags, and outputs a 4-bit state code for the hex state display.

## Interface
- `TIMEOUT`, default 5000: number of consecutive clock cycles in ESPERA without `jogada` that ends the round with a timeout (minimum 2).
- `clock`  input  1  single system clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high; takes priority over every other input.
- `iniciar`  input  1  level; starts a round (from INICIAL) or restarts one (from any final state).
- `jogada`  input  1  single-cycle pulse from the datapath edge detector: the player has set the switches.
- `igual`  input  1  registered chaves equal the memory word at the current address.
- `fimC`  input  1  address counter is at its last address.
- `zeraC`  output  1  clear address counter.
- `contaC`  output  1  increment address counter.
- `zeraR`  output  1  clear chaves register.
- `registraR`  output  1  load chaves register.
- `pronto`  output  1  round finished; asserted in every final state.
- `acertou`  output  1  round finished with every move correct.
- `errou`  output  1  round finished because of a wrong move or a timeout.
- `timeout`  output  1  round finished because of a timeout; `errou` is also asserted.
- `db_estado`  output  4  current state code.

## Operation
- State register is 4 bits. All outputs decode from the state only (pure Moore), so each output is active for exactly the cycles spent in its state.
- States, with their code, active outputs and transitions:
  - INICIAL (0x0): no outputs. Goes to PREPARA when `iniciar`=1, otherwise stays.
  - PREPARA (0x1): `zeraC`, `zeraR`. Always goes to ESPERA.
  - ESPERA (0x2): no outputs. Goes to REGISTRA when `jogada`=1. Otherwise goes to FIM_TIMEOUT when the timeout counter equals TIMEOUT-1. Otherwise stays.
  - REGISTRA (0x4): `registraR`. Always goes to COMPARA.
  - COMPARA (0x5): no outputs.
    - Goes to FIM_ERROU when `igual`=0.
    - Otherwise goes to FIM_ACERTOU when `fimC`=1.
    - Otherwise goes to PROXIMO.
  - PROXIMO (0x6): `contaC`. Always goes to ESPERA.
  - FIM_ACERTOU (0xA): `pronto`, `acertou`.
  - FIM_ERROU (0xE): `pronto`, `errou`.
  - FIM_TIMEOUT (0xD): `pronto`, `errou`, `timeout`.
  - Each of the three final states goes to PREPARA when `iniciar`=1, otherwise stays.
- `db_estado` equals the state code. An illegal code shows on `db_estado` for one cycle, with all other outputs 0, then the state returns to INICIAL.
- Timeout counter:
  - Unsigned, width ceil(log2(TIMEOUT)).
  - Increments on every ESPERA cycle in which `jogada`=0.
  - Cleared to 0 in every other state and on each ESPERA exit.
  - It never wraps, because reaching TIMEOUT-1 leaves ESPERA.
- Boundary rules:
  - `jogada` and the timeout condition in the same cycle: `jogada` wins and the state goes to REGISTRA.
  - `jogada` pulses outside ESPERA are ignored.
  - `fimC` is examined only when `igual`=1. A wrong move at the last address gives FIM_ERROU.
  - `iniciar` held high through a final state restarts the round immediately; there is no edge requirement.
  - Only the timeout counter restarts per move. Elapsed time is not carried across moves.

## Timing
- Reset is sampled at a rising edge. On the following cycle the state is INICIAL, the timeout counter is 0, every output is 0 and `db_estado`=0x0.
- Reset mid-round, including in a final state, abandons the round at the next edge with no strobes emitted.
- `iniciar` sampled high in INICIAL at edge k:
  - PREPARA during cycle k+1: `zeraC` and `zeraR` high for one cycle.
  - ESPERA from cycle k+2.
- `jogada` sampled in ESPERA at edge m:
  - REGISTRA during m+1: `registraR` for one cycle.
  - COMPARA during m+2, sampling `igual` and `fimC` at the end of m+2. The datapath must settle them within that single cycle after the load.
  - At m+3: PROXIMO (`contaC` for one cycle), or a final state.
  - ESPERA again at m+4 on a correct, non-last move.
- Minimum cost of a correct, non-last move: 4 cycles, counted from entering ESPERA.
- Timeout: entering ESPERA at cycle t with no `jogada` gives FIM_TIMEOUT during cycle t+TIMEOUT.
- Strobes are mutually exclusive and never overlap across states.

## Test plan
- Reset, then idle with `iniciar`=0 for 10 cycles -> all outputs 0 and `db_estado`=0x0 throughout. Then `iniciar` for 1 cycle -> `zeraC`=`zeraR`=1 for exactly one cycle, then `db_estado`=0x2.
- Full correct round over 16 addresses (`igual`=1 on every move, `fimC`=1 on the 16th) -> 16 `registraR` pulses, 15 `contaC` pulses, then `pronto`=`acertou`=1, `errou`=0, `db_estado`=0xA, held until `iniciar`.
- Wrong move on the 3rd address (`igual`=0) -> 3 `registraR` pulses, 2 `contaC` pulses, then `pronto`=`errou`=1, `acertou`=`timeout`=0, `db_estado`=0xE. Repeat with `igual`=0 and `fimC`=1 on the last address -> FIM_ERROU (0xE), not FIM_ACERTOU.
- TIMEOUT=8, no `jogada` after entering ESPERA -> exactly 8 cycles at 0x2, then `db_estado`=0xD with `pronto`=`errou`=`timeout`=1. Repeat with `jogada` in the 8th ESPERA cycle -> REGISTRA (0x4), no timeout.
- Assert `reset` for one cycle while in PROXIMO, and again while in FIM_ACERTOU -> INICIAL at the next edge with all outputs 0. Then `iniciar` from FIM_ERROU -> PREPARA with a fresh timeout count. A `jogada` pulse outside ESPERA (e.g. in REGISTRA) produces no extra `registraR`.
